// File: rtl/ripple_adder_pipe_if.sv
// Handshake and operand/result bundle for ripple_adder_pipe.
// Port sub exists only when RIPPLE_ADDER_PIPE_SUB_EN is defined.
interface ripple_adder_pipe_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef RIPPLE_ADDER_PIPE_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

`ifdef RIPPLE_ADDER_PIPE_SUB_EN
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
`else
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
`endif
endinterface

// File: rtl/ripple_adder_pipe.sv
// Pipelined ripple-carry adder: one SEG-bit slice per stage, carry registered between stages.
// Optional subtract mode (port sub) is enabled by defining RIPPLE_ADDER_PIPE_SUB_EN.
module ripple_adder_pipe #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input logic           clk,
    input logic           rst,
    ripple_adder_pipe_if.slave bus
);
    localparam int STAGES = (SEG > 0) ? (WIDTH / SEG) : 1;
    localparam int LAST   = STAGES - 1;
    localparam int MSB    = WIDTH - 1;

    if (WIDTH < 1 || SEG < 1 || (WIDTH % SEG) != 0) begin : g_bad_cfg
        $error("ripple_adder_pipe: WIDTH must be >= 1 and a multiple of SEG");
    end

    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

`ifdef RIPPLE_ADDER_PIPE_SUB_EN
    assign b_eff   = bus.sub ? ~bus.b : bus.b;
    assign cin_eff = bus.sub ? 1'b1 : bus.cin;
`else
    assign b_eff   = bus.b;
    assign cin_eff = bus.cin;
`endif

    // Stage inputs: stage 0 from the bus, stage k from register k-1
    logic [WIDTH-1:0] a_in   [STAGES];
    logic [WIDTH-1:0] b_in   [STAGES];
    logic [WIDTH-1:0] s_in   [STAGES];
    logic             c_in   [STAGES];
    logic [SEG:0]     slice  [STAGES];
    logic [WIDTH-1:0] s_nxt  [STAGES];
    logic             ovf_nxt;

    // Pipeline registers; element k is the register after stage k
    logic [WIDTH-1:0] a_p    [STAGES];
    logic [WIDTH-1:0] b_p    [STAGES];
    logic [WIDTH-1:0] sum_p  [STAGES];
    logic             c_p    [STAGES];
    logic [STAGES-1:0] vld_p;
    logic             ovf_p;
    logic             adv;

    assign adv = !vld_p[LAST] | bus.out_ready;

    always_comb begin
        a_in[0] = bus.a;
        b_in[0] = b_eff;
        s_in[0] = '0;
        c_in[0] = cin_eff;
        for (int k = 1; k < STAGES; k++) begin
            a_in[k] = a_p[k-1];
            b_in[k] = b_p[k-1];
            s_in[k] = sum_p[k-1];
            c_in[k] = c_p[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            slice[k] = {1'b0, a_in[k][k*SEG +: SEG]}
                     + {1'b0, b_in[k][k*SEG +: SEG]}
                     + {{SEG{1'b0}}, c_in[k]};
            s_nxt[k] = s_in[k];
            s_nxt[k][k*SEG +: SEG] = slice[k][SEG-1:0];
        end
        // The last stage sees the MSB of both operands and of the finished sum
        ovf_nxt = (a_in[LAST][MSB] == b_in[LAST][MSB]) &
                  (s_nxt[LAST][MSB] != a_in[LAST][MSB]);
    end

    // ---- stage boundaries: every stage shifts together on adv ----
    always_ff @(posedge clk) begin
        if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                a_p[k]   <= a_in[k];
                b_p[k]   <= b_in[k];
                sum_p[k] <= s_nxt[k];
                c_p[k]   <= slice[k][SEG];
            end
            ovf_p <= ovf_nxt;
            vld_p[0] <= bus.in_valid;
            for (int k = 1; k < STAGES; k++) begin
                vld_p[k] <= vld_p[k-1];
            end
        end
        // Reset drops everything in flight and zeroes the visible result
        if (rst) begin
            vld_p       <= '0;
            sum_p[LAST] <= '0;
            c_p[LAST]   <= 1'b0;
            ovf_p       <= 1'b0;
        end
    end

    assign bus.in_ready  = adv;
    assign bus.out_valid = vld_p[LAST];
    assign bus.sum       = sum_p[LAST];
    assign bus.cout      = c_p[LAST];
    assign bus.ovf       = ovf_p;
endmodule
